// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scanner:
//                scanner state enum, key code constants and the
//                (row, col) -> key code mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Keypad legend: r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: * 0 # D
    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_sync
//  Description : 4-bit two-flop synchronizer for the asynchronous column
//                inputs. Resets to all-ones (no key pressed).
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_async [3:0]   asynchronous column inputs
//                o_sync  [3:0]   synchronized columns (2-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_async,
    output logic [3:0] o_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 4'b1111;
            r_sync <= 4'b1111;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Drives one row low at a time,
//                samples synchronized active-low columns, debounces press
//                and release and emits a key code with a one-cycle strobe.
//  Ports       : clk, rst_n        clock / async active-low reset
//                LINE     [3:0]    row drive, one-hot active-low
//                COLLUMMN [3:0]    column sense, active-low, asynchronous
//                key_code [3:0]    last accepted key code
//                key_valid         one-cycle pulse on acceptance
//                key_pressed       high from acceptance until release
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] LINE,
    input  logic [3:0] COLLUMMN,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int c_MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         w_sync;
    state_t             r_state, w_state_n;
    logic [1:0]         r_row, w_row_n;
    logic [1:0]         r_col, w_col_n;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_n;
    logic [3:0]         r_line, w_line_n;
    logic [3:0]         r_key_code, w_key_code_n;
    logic               r_key_valid, w_key_valid_n;
    logic               r_key_pressed, w_key_pressed_n;
    logic               w_any_low;
    logic [1:0]         w_first_col;
    logic               w_col_low;

    keypad_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (COLLUMMN),
        .o_sync  (w_sync)
    );

    // Lowest-index low column wins when several keys share the row.
    always_comb begin
        w_any_low   = ~&w_sync;
        w_first_col = 2'd0;
        if      (!w_sync[0]) w_first_col = 2'd0;
        else if (!w_sync[1]) w_first_col = 2'd1;
        else if (!w_sync[2]) w_first_col = 2'd2;
        else if (!w_sync[3]) w_first_col = 2'd3;
    end

    assign w_col_low = ~w_sync[r_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SCAN;
            r_row         <= 2'd0;
            r_col         <= 2'd0;
            r_cnt         <= '0;
            r_line        <= 4'b1110;
            r_key_code    <= 4'd0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_row         <= w_row_n;
            r_col         <= w_col_n;
            r_cnt         <= w_cnt_n;
            r_line        <= w_line_n;
            r_key_code    <= w_key_code_n;
            r_key_valid   <= w_key_valid_n;
            r_key_pressed <= w_key_pressed_n;
        end
    end

    // Counters only increment below their terminal value and are cleared on
    // every state change, so they can never wrap.
    always_comb begin
        w_state_n       = r_state;
        w_row_n         = r_row;
        w_col_n         = r_col;
        w_cnt_n         = r_cnt;
        w_key_code_n    = r_key_code;
        w_key_valid_n   = 1'b0;
        w_key_pressed_n = r_key_pressed;
        case (r_state)
            SCAN: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_cnt_n = '0;
                    if (w_any_low) begin
                        w_col_n   = w_first_col;
                        w_state_n = DEBOUNCE;
                    end else begin
                        w_row_n = r_row + 2'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!w_col_low) begin
                    w_state_n = SCAN;
                    w_row_n   = r_row + 2'd1;
                    w_cnt_n   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_key_code_n    = map_key(r_row, r_col);
                    w_key_valid_n   = 1'b1;
                    w_key_pressed_n = 1'b1;
                    w_state_n       = HELD;
                    w_cnt_n         = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_col_low) begin
                    w_state_n = RELEASE;
                    w_cnt_n   = '0;
                end
            end
            RELEASE: begin
                if (w_col_low) begin
                    w_state_n = HELD;
                    w_cnt_n   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_key_pressed_n = 1'b0;
                    w_row_n         = r_row + 2'd1;
                    w_state_n       = SCAN;
                    w_cnt_n         = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = SCAN;
                w_cnt_n   = '0;
            end
        endcase
        // Row drive is registered from the next row so LINE never glitches.
        w_line_n = ~(4'b0001 << w_row_n);
    end

    assign LINE        = r_line;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with a physical
//                keypad model, expected-code scoreboard and pulse monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  LINE;
    logic [3:0]  COLLUMMN;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;

    logic [15:0] keys = 16'h0;          // keys[row*4+col] = physically pressed
    int          code_of [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int          exp_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          min_pulse_cyc = 0;
    int          exp_code;
    logic        prev_valid = 1'b0;

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .LINE        (LINE),
        .COLLUMMN    (COLLUMMN),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row to its column; columns idle high.
    always_comb begin
        COLLUMMN = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (LINE[r] === 1'b0)) COLLUMMN[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && key_valid === 1'b1) begin
            check("valid_one_cycle", prev_valid, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", key_code, 99);
            end else begin
                exp_code = exp_q.pop_front();
                check("key_code", key_code, exp_code);
            end
            check("pressed_with_valid", key_pressed, 1);
            if (min_pulse_cyc > 0) begin
                check("fresh_scan_latency", cyc >= min_pulse_cyc, 1);
                min_pulse_cyc = 0;
            end
        end
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_line(input logic [3:0] val);
        for (int i = 0; i < 100 && LINE !== val; i++) tick(1);
        check("line_reached", LINE, val);
    endtask

    task automatic wait_pressed(input logic val);
        for (int i = 0; i < 200 && key_pressed !== val; i++) tick(1);
        check("key_pressed_reached", key_pressed, val);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick(1);
        check("pulse_seen", exp_q.size(), 0);
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_line;
        int         k;
        one = 4'b0001;

        // Reset and idle row rotation
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_line", LINE, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_pressed", key_pressed, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            exp_line = ~(one << ((e / 4) % 4));
            check("idle_rotation", LINE, exp_line);
        end

        // Clean press of '5', held 200 cycles
        wait_line(4'b1101);
        keys[5] = 1'b1;
        exp_q.push_back(code_of[5]);
        wait_pressed(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(20);
            check("held_5_pressed", key_pressed, 1);
        end
        keys = 16'h0;
        tick(30);
        check("release_5", key_pressed, 0);

        // Bounce on '9': short low inside debounce, scan resumes at row 3
        wait_line(4'b0111);
        wait_line(4'b1011);
        keys[10] = 1'b1;
        tick(5);
        keys = 16'h0;
        tick(4);
        check("bounce_9_line", LINE, 4'b0111);
        check("bounce_9_pressed", key_pressed, 0);
        tick(20);

        // Release bounce on '#'
        keys[14] = 1'b1;
        exp_q.push_back(code_of[14]);
        wait_pressed(1'b1);
        tick(10);
        keys = 16'h0;
        tick(3);
        keys[14] = 1'b1;
        tick(2);
        keys = 16'h0;
        check("hash_bounce_pressed", key_pressed, 1);
        tick(7);
        check("hash_partial_release", key_pressed, 1);
        wait_pressed(1'b0);
        check("hash_code_held", key_code, 15);

        // Two keys on row 0: '1' wins, 'A' reported after '1' is released
        tick(10);
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        exp_q.push_back(code_of[0]);
        wait_pressed(1'b1);
        tick(20);
        keys[0] = 1'b0;
        exp_q.push_back(code_of[3]);
        wait_drained();
        keys = 16'h0;
        wait_pressed(1'b0);

        // Reset in the middle of debouncing '7'
        wait_line(4'b0111);
        wait_line(4'b1011);
        keys[8] = 1'b1;
        tick(9);
        rst_n = 1'b0;
        #1;
        check("midrst_line", LINE, 4'b1110);
        check("midrst_pressed", key_pressed, 0);
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        min_pulse_cyc = cyc + 18;
        exp_q.push_back(code_of[8]);
        wait_drained();
        keys = 16'h0;
        wait_pressed(1'b0);
        tick(10);

        // Randomized presses and glitches
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                keys[k] = 1'b1;
                tick($urandom_range(1, 3));
                keys = 16'h0;
                tick(20);
                check("glitch_no_press", key_pressed, 0);
            end else begin
                keys[k] = 1'b1;
                exp_q.push_back(code_of[k]);
                tick($urandom_range(60, 120));
                check("rand_pressed", key_pressed, 1);
                keys = 16'h0;
                tick($urandom_range(30, 50));
                check("rand_released", key_pressed, 0);
            end
        end

        wait_drained();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
